// File: rtl/mem_rsp_pkg.sv
// Shared types and constants for the memory-port responder.
// Pure declarations: no latency and no backpressure of its own.
package mem_rsp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] TAG_INSTR = 2'd0;
  localparam logic [1:0] TAG_DATA  = 2'd1;
  localparam logic [1:0] TAG_STACK = 2'd2;
  localparam logic [1:0] TAG_IO    = 2'd3;

  localparam int MAX_WAIT_STATES = 7;
  localparam int CNT_W           = 3;

endpackage

// File: rtl/mem_port_responder_if.sv
// Request/response bus between the arbiter (master) and the memory responder (slave).
// Two independent valid/ready handshakes; neither side may drop valid before ready.
interface mem_port_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [1:0]        req_tag;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_tag;
  logic              rsp_err;
  logic              busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_tag, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_tag, rsp_err, busy
  );

endinterface

// File: rtl/mem_rsp_array.sv
// Single-port storage: synchronous write, registered read, one access per enabled edge.
// One-cycle read latency; no backpressure, the caller enables it only at the access edge.
module mem_rsp_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  // Contents survive reset so software-visible memory is not lost on a block reset.
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_port_responder.sv
// Memory-side responder: one request at a time, WAIT_STATES extra cycles, tagged response.
// Accept at k, response valid at k+WAIT_STATES+1; req_ready is low until the response handshakes.
module mem_port_responder
  import mem_rsp_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WAIT_STATES = 2,
  parameter int ROM_TOP     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_port_responder_if.slave   bus
);

  localparam logic [CNT_W-1:0] WS      = WAIT_STATES[CNT_W-1:0];
  localparam logic [ADDR_W:0]  ROM_LIM = ROM_TOP[ADDR_W:0];

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              cap_write;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic [1:0]        cap_tag;
  logic [1:0]        rsp_tag_q;
  logic              rsp_err_q;
  logic              accept;
  logic              access;
  logic              rsp_done;
  logic              protect_hit;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    access    = 1'b0;
    rsp_done  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          access    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  generate
    if (ROM_TOP > 0) begin : g_rom
      assign protect_hit = ({1'b0, cap_addr} < ROM_LIM);
    end else begin : g_no_rom
      assign protect_hit = 1'b0;
    end
  endgenerate

  assign mem_we = access & cap_write & ~protect_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_tag   <= '0;
      rsp_tag_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (accept) begin
        cap_write <= bus.req_write;
        cap_addr  <= bus.req_addr;
        cap_wdata <= bus.req_wdata;
        cap_tag   <= bus.req_tag;
        cnt       <= WS;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      // Response side-band is loaded at the access edge and zeroed once handed off.
      if (access) begin
        rsp_tag_q <= cap_tag;
        rsp_err_q <= cap_write & protect_hit;
      end else if (rsp_done) begin
        rsp_tag_q <= '0;
        rsp_err_q <= 1'b0;
      end
    end
  end

  // A protected write turns into a harmless read; its data is masked below.
  mem_rsp_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .en    (access),
    .we    (mem_we),
    .addr  (cap_addr),
    .wdata (cap_wdata),
    .rdata (mem_rdata)
  );

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.busy      = (state != IDLE);
  assign bus.rsp_tag   = rsp_tag_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = (state == RESP && !cap_write) ? mem_rdata : '0;

endmodule
